// File: rtl/checker_psync_tx.sv
// Transmit side of a toggle-encoded pulse crossing. Each event pulse becomes one
// transition on `level`. Transitions are spaced by HOLDOFF cycles, and excess events are queued.
module checker_psync_tx #(
   parameter int HOLDOFF   = 4,
   parameter int CNT_WIDTH = 4
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 i,
   input  logic                 ovf_clr,
   output logic                 level,
   output logic [CNT_WIDTH-1:0] pending,
   output logic                 busy,
   output logic                 overflow
);

   localparam int TW = $clog2(HOLDOFF) + 1;
   localparam logic [TW-1:0]        TIMER_LOAD = TW'(HOLDOFF - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

   logic [TW-1:0]        timer_reg;
   logic                 emit;
   logic                 drop;
   logic [CNT_WIDTH-1:0] pending_next;

   // A fresh event with an empty queue is sent straight away instead of being counted.
   assign emit = (timer_reg == '0) && ((pending != '0) || i);
   assign drop = i && !emit && (pending == CNT_MAX);

   always_comb begin
      pending_next = pending;
      if (i && !emit && !drop) begin
         pending_next = pending + CNT_ONE;
      end else if (!i && emit) begin
         pending_next = pending - CNT_ONE;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         level     <= 1'b0;
         pending   <= '0;
         timer_reg <= '0;
         overflow  <= 1'b0;
      end else begin
         pending <= pending_next;
         if (emit) begin
            level     <= ~level;
            timer_reg <= TIMER_LOAD;
         end else if (timer_reg != '0) begin
            timer_reg <= timer_reg - TW'(1);
         end
         // A drop in the same cycle beats a clear request.
         if (drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   assign busy = (pending != '0) || (timer_reg != '0);

endmodule

// File: tb/tb_checker_psync_tx.sv
// Scoreboard bench for checker_psync_tx. Expected toggle edges are queued by the stimulus.
// A negedge monitor pops and compares them. A second instance feeds a far-domain receiver model.
module tb_checker_psync_tx;

   logic       sys_clk = 1'b0;
   logic       far_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       i = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       level;
   logic [3:0] pending;
   logic       busy;
   logic       overflow;

   logic       i2 = 1'b0;
   logic       level2;
   logic [3:0] pending2;
   logic       busy2;
   logic       overflow2;

   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;
   logic rst_at_edge = 1'b1;
   logic prev_level = 1'b0;
   int exp_q[$];
   int exp_edge;
   int base;

   logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
   int rx_cnt = 0;

   checker_psync_tx #(.HOLDOFF(4), .CNT_WIDTH(4)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .i(i), .ovf_clr(ovf_clr),
      .level(level), .pending(pending), .busy(busy), .overflow(overflow)
   );

   checker_psync_tx #(.HOLDOFF(7), .CNT_WIDTH(4)) dut_e2e (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .i(i2), .ovf_clr(1'b0),
      .level(level2), .pending(pending2), .busy(busy2), .overflow(overflow2)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #7;
      forever #15 far_clk = ~far_clk;
   end

   // Far-domain receiver: two-flop sampler, a delay flop, and an XOR edge detect.
   always @(posedge far_clk) begin
      s1 <= level2;
      s2 <= s1;
      s3 <= s2;
      if (s2 ^ s3) rx_cnt <= rx_cnt + 1;
   end

   always @(posedge sys_clk) begin
      edge_cnt    <= edge_cnt + 1;
      rst_at_edge <= sys_rst;
   end

   always @(negedge sys_clk) begin
      if (level !== prev_level) begin
         if (!rst_at_edge) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL toggle_unexpected: toggle at edge %0d, required none", edge_cnt - 1);
            end else begin
               exp_edge = exp_q.pop_front();
               if (exp_edge != edge_cnt - 1) begin
                  failures++;
                  $display("FAIL toggle_edge: toggle at edge %0d, required edge %0d",
                           edge_cnt - 1, exp_edge);
               end else begin
                  $display("toggle edge=%0d level=%b", edge_cnt - 1, level);
               end
            end
         end
         prev_level = level;
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      i = 1'b0;
      ovf_clr = 1'b0;
      tick();
      sys_rst = 1'b0;
   endtask

   initial begin
      int sent;
      int len;
      int rx_base;

      // Single pulse
      do_reset();
      chk("rst_level", int'(level), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overflow", int'(overflow), 0);
      base = edge_cnt;
      exp_q.push_back(base);
      i = 1'b1;
      tick();
      i = 1'b0;
      chk("t1_level", int'(level), 1);
      chk("t1_pending", int'(pending), 0);
      chk("t1_busy_e0", int'(busy), 1);
      tick();
      chk("t1_busy_e1", int'(busy), 1);
      tick();
      chk("t1_busy_e2", int'(busy), 1);
      tick();
      chk("t1_busy_e3", int'(busy), 0);
      repeat (10) tick();
      chk("t1_queue_left", exp_q.size(), 0);
      chk("t1_level_end", int'(level), 1);

      // Burst of 3
      do_reset();
      base = edge_cnt;
      exp_q.push_back(base);
      exp_q.push_back(base + 4);
      exp_q.push_back(base + 8);
      for (int k = 0; k <= 11; k++) begin
         i = (k <= 2);
         tick();
         case (k)
            1:  chk("t2_pend_e1", int'(pending), 1);
            2:  chk("t2_pend_e2", int'(pending), 2);
            3:  chk("t2_pend_e3", int'(pending), 2);
            4:  chk("t2_pend_e4", int'(pending), 1);
            8:  chk("t2_pend_e8", int'(pending), 0);
            11: begin
               chk("t2_level", int'(level), 1);
               chk("t2_busy_e11", int'(busy), 0);
            end
            default: ;
         endcase
      end
      i = 1'b0;
      repeat (5) tick();
      chk("t2_queue_left", exp_q.size(), 0);

      // Saturation, then overflow clear behaviour
      do_reset();
      base = edge_cnt;
      for (int n = 0; n <= 20; n++) exp_q.push_back(base + 4 * n);
      for (int k = 0; k <= 90; k++) begin
         i = (k <= 23);
         ovf_clr = (k == 22) || (k == 30);
         tick();
         case (k)
            19: chk("t3_pend_e19", int'(pending), 15);
            20: begin
               chk("t3_pend_e20", int'(pending), 15);
               chk("t3_ovf_e20", int'(overflow), 0);
            end
            21: begin
               chk("t3_pend_e21", int'(pending), 15);
               chk("t3_ovf_e21", int'(overflow), 1);
            end
            22: chk("t4_ovf_set_wins", int'(overflow), 1);
            23: chk("t3_pend_e23", int'(pending), 15);
            24: chk("t3_pend_e24", int'(pending), 14);
            29: chk("t4_ovf_sticky", int'(overflow), 1);
            30: chk("t4_ovf_cleared", int'(overflow), 0);
            80: begin
               chk("t3_pend_e80", int'(pending), 0);
               chk("t3_busy_e80", int'(busy), 1);
            end
            83: chk("t3_busy_e83", int'(busy), 0);
            90: chk("t3_level", int'(level), 1);
            default: ;
         endcase
      end
      i = 1'b0;
      ovf_clr = 1'b0;
      tick();
      chk("t3_queue_left", exp_q.size(), 0);

      // Reset mid-burst
      do_reset();
      base = edge_cnt;
      exp_q.push_back(base);
      exp_q.push_back(base + 4);
      exp_q.push_back(base + 8);
      for (int k = 0; k <= 8; k++) begin
         i = (k <= 7);
         tick();
      end
      i = 1'b0;
      chk("t5_pend_pre", int'(pending), 5);
      chk("t5_level_pre", int'(level), 1);
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      chk("t5_level", int'(level), 0);
      chk("t5_pending", int'(pending), 0);
      chk("t5_busy", int'(busy), 0);
      chk("t5_overflow", int'(overflow), 0);
      repeat (20) tick();
      chk("t5_queue_left", exp_q.size(), 0);
      base = edge_cnt;
      exp_q.push_back(base);
      i = 1'b1;
      tick();
      i = 1'b0;
      chk("t5_level_new", int'(level), 1);
      repeat (6) tick();
      chk("t5_queue_end", exp_q.size(), 0);

      // End-to-end through the far-domain receiver
      repeat (20) tick();
      rx_base = rx_cnt;
      sent = 0;
      while (sent < 50) begin
         len = int'($urandom_range(1, 8));
         if (len > 50 - sent) len = 50 - sent;
         $display("e2e burst len=%0d sent_before=%0d", len, sent);
         repeat (len) begin
            i2 = 1'b1;
            tick();
         end
         i2 = 1'b0;
         sent += len;
         repeat (len * 7 + 5) tick();
      end
      repeat (100) tick();
      chk("t6_rx_pulses", rx_cnt - rx_base, 50);
      chk("t6_overflow", int'(overflow2), 0);
      chk("t6_pending", int'(pending2), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/checker_psync_tx.md
# checker_psync_tx

Transmit end of the checker's toggle-encoded pulse crossing. It accepts single-cycle event pulses in the `sys_clk` domain and encodes each one as a transition on a level output. The far domain's toggle pulse synchronizer (3-flop sampler plus XOR edge detect) turns each transition back into one pulse. Successive transitions are spaced by a programmable hold-off, so the slower far domain never merges two toggles. Events that arrive faster than they can be sent are queued in a saturating counter, and any event lost is flagged.

## Interface
- `HOLDOFF`, default 4: minimum `sys_clk` cycles between level transitions. Legal values ≥ 1. Set it to at least 2 × (far clock period / `sys_clk` period) + 1.
- `CNT_WIDTH`, default 4: width of the pending-event counter. Maximum queued events = 2^`CNT_WIDTH` − 1.
- `sys_clk`  in  1  sole clock; all state is updated on its rising edge.
- `sys_rst`  in  1  reset, synchronous and active-high.
- `i`  in  1  event pulse; each cycle `i`=1 is one event.
- `level`  out  1  toggle output to the far-domain synchronizer. Driven directly by a flop.
- `pending`  out  `CNT_WIDTH`  number of events queued and not yet emitted.
- `busy`  out  1  (`pending` ≠ 0) or (hold-off timer ≠ 0).
- `overflow`  out  1  sticky; set when an event is dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Internal state: `level`, `pending`, `timer` (width ceil(log2(`HOLDOFF`))+1), `overflow`.
- Emit condition: `emit` = (`timer` == 0) and (`pending` ≠ 0 or `i`). An incoming event with an empty queue bypasses the counter.
- On `emit`:
  - `level` ← ~`level`.
  - `timer` ← `HOLDOFF` − 1.
- Otherwise, when `timer` ≠ 0: `timer` ← `timer` − 1.
- Counter update: `pending` ← `pending` + `i` − `emit`.
  - `i` and `emit` in the same cycle leave `pending` unchanged.
  - An emit triggered by `i` with `pending` = 0 also leaves it at 0.
- Saturation: when `i`=1, `emit`=0 and `pending` = 2^`CNT_WIDTH` − 1:
  - the event is dropped;
  - `pending` holds;
  - `overflow` ← 1.
- `overflow` clear: `ovf_clr`=1 clears it, unless a drop occurs in the same cycle. Set wins.
- `HOLDOFF`=1: `timer` is always 0, so one emission is possible per cycle.
- Reset, at any time including mid-burst: `level`=0, `pending`=0, `timer`=0, `overflow`=0. Queued events are discarded.
  - If `level` was 1 when reset hit, the far side sees one extra pulse.
  - Both domains are reset together; this is accepted behaviour.

## Timing
- All outputs are registered except `busy`, which is a combinational OR of registered state.
- Latency: `i` sampled at edge N with the transmitter idle → `level` toggles after edge N. The far side sees the pulse after 3 far-clock edges.
- Back-to-back emissions occur at edges N, N+`HOLDOFF`, N+2·`HOLDOFF`, … while `pending` ≠ 0.
- `pending` and `overflow` reflect edge N's event after edge N.
- `busy` falls `HOLDOFF` − 1 cycles after the last emission.

## Test plan
Test plan uses `HOLDOFF`=4 and `CNT_WIDTH`=4.
1. **Single pulse.** Reset, then `i`=1 for edge 0.
   - `level` 0→1 after edge 0.
   - `pending` stays 0.
   - `busy`=1 for 3 cycles, then 0.
   - No further toggles.
2. **Burst of 3.** `i`=1 at edges 0–2.
   - Toggles at edges 0, 4, 8.
   - `pending` after edges 1, 2, 4, 8 = 1, 2, 1, 0.
   - Final `level`=1.
3. **Saturation.** `i`=1 at edges 0–23.
   - `pending` after edge 19 = 15; edge 20 emits, so it stays 15.
   - Edges 21–23 drop; `overflow`=1 after edge 21.
   - Emissions continue every 4 cycles until `pending`=0: 21 toggles total, final `level`=1.
4. **Overflow clear.**
   - With `overflow`=1: `ovf_clr`=1 coincident with a drop → `overflow` stays 1.
   - `ovf_clr`=1 alone → `overflow` 0 after the edge.
5. **Reset mid-burst.** Assert `sys_rst` with `pending`=5 and `level`=1.
   - After the edge: `level`=0, `pending`=0, `busy`=0, `overflow`=0.
   - No toggles until the next `i`.
6. **End-to-end.** Connect to the toggle synchronizer receiver with a far clock 3× slower and `HOLDOFF`=7. Send 50 random pulses, including bursts.
   - Receiver output pulse count = 50.
   - `overflow`=0.
